// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit pipeline: drives a req/ack handshake to data memory
// for loads and stores, and produces the MEM/WB register. `MEM_TIMEOUT_EN` adds a WAIT abort.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [1:0]  IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [2:0]  IRd,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        stall,
  output logic [15:0] ALUResultMEM,
  output logic        ORegWrite,
  output logic [1:0]  ORegStore,
  output logic [15:0] OPCP2,
  output logic [15:0] OALUResult,
  output logic [2:0]  ORd,
  output logic [15:0] OLoadData,
  output logic [15:0] loadDataWB,
  output logic        mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  if ((1 << TO_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("TO_W is too narrow to count to TIMEOUT_CYCLES");
  end

  logic [0:0]  r_state;
  logic        r_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_oregwrite;
  logic [1:0]  r_oregstore;
  logic [15:0] r_opcp2;
  logic [15:0] r_oalu;
  logic [2:0]  r_ord;
  logic [15:0] r_oload;

  logic        w_memop;
  logic        w_timeout;
  logic        w_stall;
  logic        w_wb_load;
  logic        w_wb_regwrite;
  logic [15:0] w_wb_ld;
  logic        w_start;
  logic        w_done;
  logic        w_abort;

  assign w_memop = IMemRead | IMemWrite;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign mem_err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Stage control decode: when to stall, and what the MEM/WB register captures
  always_comb begin
    w_stall       = 1'b0;
    w_wb_load     = 1'b0;
    w_wb_regwrite = IRegWrite;
    w_wb_ld       = 16'h0000;
    w_start       = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memop) begin
          w_stall = 1'b1;
          w_start = 1'b1;
        end else begin
          w_wb_load = 1'b1;
        end
      end
      ST_WAIT: begin
        // an ack coinciding with expiry wins and completes normally
        if (dmem_ack) begin
          w_wb_load = 1'b1;
          w_done    = 1'b1;
          w_wb_ld   = IMemWrite ? 16'h0000 : dmem_rdata;
        end else if (w_timeout) begin
          w_wb_load     = 1'b1;
          w_done        = 1'b1;
          w_abort       = 1'b1;
          w_wb_regwrite = 1'b0;
          w_wb_ld       = 16'hDEAD;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  // Reset forces stall low at once, even with a memop still presented
  assign stall        = w_stall & ~reset;
  assign ALUResultMEM = IALUResult;

  // FSM and registered memory interface
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else if (w_start) begin
      r_state <= ST_WAIT;
      r_req   <= 1'b1;
      r_we    <= IMemWrite;
      r_addr  <= IALUResult;
      r_wdata <= I3rdArg;
    end else if (w_done) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= r_state;
    end
  end

  // MEM/WB register: captures the instruction, or a bubble while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oregwrite <= 1'b0;
      r_oregstore <= 2'b00;
      r_opcp2     <= 16'h0000;
      r_oalu      <= 16'h0000;
      r_ord       <= 3'b000;
      r_oload     <= 16'h0000;
    end else if (w_wb_load) begin
      r_oregwrite <= w_wb_regwrite;
      r_oregstore <= IRegStore;
      r_opcp2     <= IPCP2;
      r_oalu      <= IALUResult;
      r_ord       <= IRd;
      r_oload     <= w_wb_ld;
    end else begin
      r_oregwrite <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else if (w_start) begin
      r_to_cnt <= '0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end else if (r_state == ST_WAIT && !dmem_ack && !w_timeout) begin
      r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`endif

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign ORegWrite  = r_oregwrite;
  assign ORegStore  = r_oregstore;
  assign OPCP2      = r_opcp2;
  assign OALUResult = r_oalu;
  assign ORd        = r_ord;
  assign OLoadData  = r_oload;
  assign loadDataWB = r_oload;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 16-bit pipeline.
- Consumes the EX/MEM pipeline register contents, runs a request/acknowledge transaction to a variable-latency data memory for loads and stores, and produces the MEM/WB pipeline register.
- Drives a pipeline stall while a memory transaction is outstanding.
- Exports the forwarding values ALUResultMEM and loadDataWB back to the execute stage.

Parameters:
- TIMEOUT_CYCLES, 15: maximum WAIT cycles before abort. Used only with MEM_TIMEOUT_EN.
- TO_W, 4: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- IRegWrite  in  1  EX/MEM register-write control.
- IMemWrite  in  1  EX/MEM store request.
- IMemRead  in  1  EX/MEM load request.
- IRegStore  in  2  EX/MEM writeback source select; passed through.
- IPCP2  in  16  EX/MEM PC+2; passed through.
- IALUResult  in  16  EX/MEM ALU result; used as the memory address.
- I3rdArg  in  16  EX/MEM store data.
- IRd  in  3  EX/MEM destination register.
- dmem_ack  in  1  data memory done. Valid only while dmem_req=1.
- dmem_rdata  in  16  load data. Valid with dmem_ack.
- dmem_req  out  1  registered memory request.
- dmem_we  out  1  registered write enable.
- dmem_addr  out  16  registered address.
- dmem_wdata  out  16  registered store data.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- ALUResultMEM  out  16  equals IALUResult (combinational forward).
- ORegWrite, ORegStore[1:0], OPCP2[15:0], OALUResult[15:0], ORd[2:0]  out  MEM/WB register outputs.
- OLoadData  out  16  MEM/WB load data.
- loadDataWB  out  16  equals OLoadData.
- mem_err  out  1  sticky timeout flag. Constant 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, at any time, including mid-transaction):
  - state goes to IDLE.
  - All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, every MEM/WB output, mem_err, timeout counter.
- memop = IMemRead | IMemWrite.
- If both IMemRead and IMemWrite are set, the operation is treated as a store (dmem_we=1).
- FSM has two states, IDLE and WAIT.
- IDLE, memop=0:
  - stall=0.
  - Next edge: MEM/WB loads the inputs and OLoadData<=0.
  - Latency is 1 cycle; no memory activity.
- IDLE, memop=1:
  - stall=1.
  - Next edge: dmem_req<=1, dmem_we<=IMemWrite, dmem_addr<=IALUResult, dmem_wdata<=I3rdArg; state<=WAIT.
  - MEM/WB loads a bubble: ORegWrite<=0, other MEM/WB fields hold.
- WAIT, dmem_ack=0:
  - stall=1.
  - MEM/WB loads a bubble each edge.
  - dmem_* outputs hold.
- WAIT, dmem_ack=1:
  - stall=0.
  - Next edge: MEM/WB loads the EX/MEM inputs (held stable by the stall). OLoadData<=dmem_rdata for a load, 0 for a store.
  - dmem_req<=0, dmem_we<=0; state<=IDLE.
- Minimum memory op: 1 stall cycle, with ack in the first WAIT cycle.
- A back-to-back memory op is re-detected in IDLE on the following cycle. dmem_req is therefore low for at least one cycle between transactions.
- dmem_ack while in IDLE is ignored.
- dmem_rdata is sampled only on the ack edge.
- ALUResultMEM is combinational from IALUResult and is unaffected by stall.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on IDLE->WAIT and increments every WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack, the transaction aborts: stall=0 that cycle.
  - Next edge: MEM/WB loads the instruction with ORegWrite<=0, OLoadData<=16'hDEAD; mem_err<=1 (sticky until reset); dmem_req<=0; state<=IDLE.
  - An ack in the same cycle as expiry takes priority and completes normally.
- Undefined: no counter; WAIT is held indefinitely; mem_err tied to 0.

Test Plan:
- ALU passthrough:
  - Stimulus: IRegWrite=1, IMemRead=0, IMemWrite=0, IALUResult=16'h0014, IRd=3, IRegStore=0, IPCP2=16'hA5A5.
  - Response: stall=0 throughout; one edge later ORegWrite=1, OALUResult=16'h0014, ORd=3, OPCP2=16'hA5A5, OLoadData=0, dmem_req=0.
- Load with ack after 3 WAIT cycles:
  - Stimulus: IMemRead=1, IALUResult=16'h0040, IRd=5, dmem_rdata=16'hBEEF on ack.
  - Response: stall=1 for 4 cycles; dmem_req=1, dmem_we=0, dmem_addr=16'h0040 during WAIT; ORegWrite=0 during stall; after the ack edge OLoadData=16'hBEEF, loadDataWB=16'hBEEF, ORd=5, dmem_req=0.
- Store with immediate ack:
  - Stimulus: IMemWrite=1, IALUResult=16'h0010, I3rdArg=16'h9ABC.
  - Response: dmem_we=1, dmem_wdata=16'h9ABC, dmem_addr=16'h0010; stall high exactly 1 cycle; OLoadData=0.
- Back-to-back loads, both acked immediately:
  - Response: dmem_req pattern 1,0,1; each load's data appears in OLoadData in order.
- Reset asserted mid-WAIT:
  - Response: dmem_req, stall and every MEM/WB output read 0 immediately, without waiting for a clock edge; a late dmem_ack after reset is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=15, load with no ack:
  - Response: after 15 WAIT cycles stall drops; next edge mem_err=1, OLoadData=16'hDEAD, ORegWrite=0, state=IDLE.
